switch_event_filter: RTL

- Conditions one raw mechanical switch into clean, single-cycle events for the digit counter that feeds the 7-segment decoder.
- Chain: synchronise, then debounce, then edge-detect, then long-press/auto-repeat FSM.
- Holding the switch auto-increments the displayed digit.
- Sits directly upstream of the counter in the display top level and replaces its ad-hoc edge detection.

---
 rtl/switch_pkg.sv | 31 +++
 rtl/switch_debounce_core.sv | 62 ++++++
 rtl/switch_event_filter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  switch_pkg
//  Shared FSM encodings, event bundle type, width helper and board defaults
//  for the switch event filter.
//  Revision: 1.0
// ============================================================================
package switch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_REPEAT  = 2'd2;

    // 25 MHz board clock: 10 ms debounce, 0.5 s hold, 0.1 s repeat.
    localparam int DEF_DEBOUNCE_CYCLES = 250_000;
    localparam int DEF_HOLD_CYCLES     = 12_500_000;
    localparam int DEF_REPEAT_CYCLES   = 2_500_000;

    typedef struct packed {
        logic press;
        logic release_ev;
        logic repeat_ev;
        logic long_ev;
    } sw_events_t;

    function automatic int width_of(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce_core.sv
`default_nettype none
// ============================================================================
//  switch_debounce_core
//  Two-flop synchroniser followed by a stable-count debouncer.
//  Revision: 1.0
// ============================================================================
module switch_debounce_core
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic sw_o,
    output logic sw_next_o
);

    localparam int               CNT_W    = width_of(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= sw_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample matching the current level restarts qualification.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign sw_o      = level_q;
    // Look-ahead lets the parent register its edge pulses in the same cycle.
    assign sw_next_o = level_d;

endmodule
`default_nettype wire

// File: rtl/switch_event_filter.sv
`default_nettype none
// ============================================================================
//  switch_event_filter
//  Debounced switch to press/release/auto-repeat single-cycle events.
//  Revision: 1.0
// ============================================================================
module switch_event_filter
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic sw_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o,
    output logic long_o
);

    localparam int                HOLD_MAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                               : REPEAT_CYCLES;
    localparam int                HOLD_W      = width_of(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    logic              level;
    logic              level_next;
    logic              rise;
    logic              fall;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    sw_events_t        evt_q;
    sw_events_t        evt_d;

    switch_debounce_core #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sw_i     (sw_i),
        .sw_o     (level),
        .sw_next_o(level_next)
    );

    assign rise = level_next & ~level;
    assign fall = ~level_next & level;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            evt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            evt_q      <= evt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        hold_cnt_d        = hold_cnt_q;
        evt_d             = '0;
        evt_d.long_ev     = evt_q.long_ev;
        // Release overrides everything, including a coincident repeat expiry.
        if (fall) begin
            state_d          = ST_IDLE;
            hold_cnt_d       = '0;
            evt_d.release_ev = 1'b1;
            evt_d.long_ev    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d     = ST_PRESSED;
                        hold_cnt_d  = '0;
                        evt_d.press = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d         = ST_REPEAT;
                        hold_cnt_d      = '0;
                        evt_d.repeat_ev = 1'b1;
                        evt_d.long_ev   = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (hold_cnt_q == REPEAT_LAST) begin
                        hold_cnt_d      = '0;
                        evt_d.repeat_ev = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    hold_cnt_d    = '0;
                    evt_d.long_ev = 1'b0;
                end
            endcase
        end
    end

    assign sw_o      = level;
    assign press_o   = evt_q.press;
    assign release_o = evt_q.release_ev;
    assign repeat_o  = evt_q.repeat_ev;
    assign long_o    = evt_q.long_ev;

endmodule
`default_nettype wire
